cpu2core_ring_writer: RTL
=========================

// Module: cpu2core_ring_writer
// PURPOSE
//  Upstream feeder for the 256x32 single-port on-chip shared memory between the two cores.
//  Accepts a 32-bit valid/ready word stream from the producer core's datapath.
//  Writes each word into the memory as a circular buffer and tracks write/read pointers.
//  Exposes an Avalon-MM CSR slave so the consumer core can advance RD_PTR and take a level IRQ.
// PARAMETERS
//  ADDR_W   8   memory word-address width; DEPTH = 2**ADDR_W = 256 words
//  DATA_W   32  stream and memory data width; the only supported value
// PORTS
//  clk             in   1        system clock
//  reset           in   1        synchronous, active-high reset
//  snk_valid       in   1        stream word valid
//  snk_data        in   DATA_W   stream word
//  snk_ready       out  1        block can accept the word this cycle
//  mem_address     out  ADDR_W   memory word address
//  mem_chipselect  out  1        memory select
//  mem_write       out  1        memory write strobe
//  mem_byteenable  out  4        always 4'hF while mem_write=1
//  mem_writedata   out  DATA_W   memory write data
//  csr_address     in   2        0=WR_PTR(RO) 1=RD_PTR(RW) 2=CTRL(RW) 3=STATUS(RO, W1C bits)
//  csr_read        in   1        CSR read strobe
//  csr_write       in   1        CSR write strobe
//  csr_writedata   in   32       CSR write data
//  csr_readdata    out  32       registered; valid 1 cycle after csr_read
//  irq             out  1        level interrupt to the consumer core
// BEHAVIOUR
//  - Reset values: all outputs 0; wr_ptr=rd_ptr=0; CTRL=0; sticky flags=0; state=DISABLED.
//  - Pointers are ADDR_W+1 bits wide. level = wr_ptr - rd_ptr (mod 2**(ADDR_W+1)), range 0..DEPTH.
//  - CTRL fields: [0] enable, [1] irq_en, [ADDR_W+8:8] threshold (ADDR_W+1 bits).
//  - States:
//    - DISABLED: snk_ready=0. Goes to RUN when enable=1.
//    - RUN: snk_ready = !full, where full = (level == DEPTH). Goes to DRAIN when enable=0.
//    - DRAIN: snk_ready=0. Completes any pending memory write, then goes to DISABLED.
//  - Accept = snk_valid & snk_ready.
//    - On accept at cycle t, wr_ptr increments at t+1.
//    - At t+1, mem_chipselect=mem_write=1, mem_address=old wr_ptr[ADDR_W-1:0], mem_writedata=word.
//    - One registered stage; back-to-back accepts give one write per cycle. Latency 1.
//  - WR_PTR CSR returns the committed pointer: it counts only writes already driven to memory.
//    A word is therefore in memory before the consumer can see the pointer advance.
//  - Full: snk_ready drops in the cycle level reaches DEPTH.
//    - Sticky STATUS[0] full_hit sets when snk_valid=1 while full.
//    - Full uses the accepted pointer, so a pending write cannot overrun.
//  - Wrap: the address wraps 255->0 naturally. The pointer MSB distinguishes full from empty.
//  - RD_PTR write:
//    - Accepted only if (committed wr_ptr - new) mod 2**(ADDR_W+1) <= DEPTH.
//    - Otherwise it is ignored and sticky STATUS[1] bad_ptr sets.
//  - STATUS read layout: [1:0] sticky flags, [ADDR_W+8:8] level, [31:30] state.
//    Writing 1 to bit 0 or 1 clears that flag.
//  - Simultaneous accept and RD_PTR write: both take effect. level and full use the new values next cycle.
//  - Same-cycle W1C and flag set: the set wins.
//  - irq = irq_en & (level >= threshold), registered (1-cycle lag).
//    threshold=0 with irq_en=1 asserts irq permanently.
//  - reset mid-write: the pending write is dropped; mem_write=0 the next cycle.
// STRUCTURE
//  - Shared package cpu2core_ring_pkg:
//    - CSR offset localparams and CTRL/STATUS bit positions
//    - state encoding typedef {DISABLED, RUN, DRAIN}
//  - One sub-module, cpu2core_ring_csr:
//    - register file, W1C logic, RD_PTR legality check, readdata register
//  - Top level holds the FSM, pointers, memory output stage and irq.
// TESTING
//  1. Reset, enable, then 4 words A0..A3 back-to-back.
//     -> mem writes to addr 0..3 on consecutive cycles; WR_PTR=4; level=4.
//  2. Fill with RD_PTR=0.
//     -> 256 accepts, then snk_ready=0; full_hit=1 with valid held.
//     Then RD_PTR:=16 -> ready returns; 16 more words go to addr 0..15; WR_PTR=0x110.
//  3. RD_PTR=WR_PTR=250, stream 10 words.
//     -> addresses 250..255 then 0..3; WR_PTR=260; level=10.
//  4. threshold=8, irq_en=1, push 8 words.
//     -> irq rises 1 cycle after the 8th accept.
//     Then RD_PTR += 1 -> irq falls.
//  5. enable:=0 in the same cycle as an accept.
//     -> that write still issues; state DRAIN -> DISABLED; snk_ready stays 0.
//  6. Illegal or racing CSR activity:
//     - RD_PTR write of WR_PTR+1 -> ignored, bad_ptr=1.
//     - W1C to bad_ptr -> 0.
//     - reset asserted with a pending write -> no mem_write next cycle.

Source files
------------

// File: rtl/cpu2core_ring_pkg.sv
// Shared definitions for the producer-to-consumer ring writer: CSR map,
// CTRL/STATUS bit positions and the writer state encoding.
package cpu2core_ring_pkg;

  localparam logic [1:0] CSR_WR_PTR = 2'd0;
  localparam logic [1:0] CSR_RD_PTR = 2'd1;
  localparam logic [1:0] CSR_CTRL   = 2'd2;
  localparam logic [1:0] CSR_STATUS = 2'd3;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_THR_LSB   = 8;

  localparam int STAT_FULL_HIT  = 0;
  localparam int STAT_BAD_PTR   = 1;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_STATE_LSB = 30;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAIN    = 2'd2
  } ring_state_t;

endpackage

// File: rtl/cpu2core_ring_csr.sv
// CSR slave for the ring writer: CTRL and RD_PTR registers, sticky W1C flags,
// RD_PTR legality check and the registered read-data path.
module cpu2core_ring_csr
  import cpu2core_ring_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  input  logic [ADDR_W:0]   cmt_ptr,
  input  logic [ADDR_W:0]   level,
  input  logic [1:0]        state,
  input  logic              full_hit_set,
  output logic              enable,
  output logic              irq_en,
  output logic [ADDR_W:0]   threshold,
  output logic [ADDR_W:0]   rd_ptr
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0] new_rd;
  logic [ADDR_W:0] rd_dist;
  logic            rd_wr;
  logic            rd_ok;
  logic            st_wr;
  logic            full_hit;
  logic            bad_ptr;
  logic [31:0]     rd_mux;
  logic            unused_wdata;

  assign new_rd  = csr_writedata[ADDR_W:0];
  // A new read pointer may never lead the committed write pointer or trail it by more than DEPTH.
  assign rd_dist = cmt_ptr - new_rd;
  assign rd_ok   = (rd_dist <= DEPTH);
  assign rd_wr   = csr_write && (csr_address == CSR_RD_PTR);
  assign st_wr   = csr_write && (csr_address == CSR_STATUS);

  assign unused_wdata = ^{csr_writedata[31:ADDR_W+9], csr_writedata[7:2]};

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    unique case (csr_address)
      CSR_WR_PTR: rd_mux[ADDR_W:0] = cmt_ptr;
      CSR_RD_PTR: rd_mux[ADDR_W:0] = rd_ptr;
      CSR_CTRL: begin
        rd_mux[CTRL_ENABLE]                          = enable;
        rd_mux[CTRL_IRQ_EN]                          = irq_en;
        rd_mux[CTRL_THR_LSB+ADDR_W:CTRL_THR_LSB]     = threshold;
      end
      default: begin
        rd_mux[STAT_FULL_HIT]                        = full_hit;
        rd_mux[STAT_BAD_PTR]                         = bad_ptr;
        rd_mux[STAT_LEVEL_LSB+ADDR_W:STAT_LEVEL_LSB] = level;
        rd_mux[STAT_STATE_LSB+1:STAT_STATE_LSB]      = state;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable       <= 1'b0;
      irq_en       <= 1'b0;
      threshold    <= '0;
      rd_ptr       <= '0;
      full_hit     <= 1'b0;
      bad_ptr      <= 1'b0;
      csr_readdata <= '0;
    end else begin
      if (rd_wr && rd_ok) rd_ptr <= new_rd;
      if (csr_write && (csr_address == CSR_CTRL)) begin
        enable    <= csr_writedata[CTRL_ENABLE];
        irq_en    <= csr_writedata[CTRL_IRQ_EN];
        threshold <= csr_writedata[CTRL_THR_LSB+ADDR_W:CTRL_THR_LSB];
      end
      // A flag being set in the same cycle as its W1C clear stays set.
      full_hit <= full_hit_set | (full_hit & ~(st_wr & csr_writedata[STAT_FULL_HIT]));
      bad_ptr  <= (rd_wr & ~rd_ok) | (bad_ptr & ~(st_wr & csr_writedata[STAT_BAD_PTR]));
      if (csr_read) csr_readdata <= rd_mux;
    end
  end

endmodule

// File: rtl/cpu2core_ring_writer.sv
// Writes a valid/ready word stream into a shared single-port memory used as a
// circular buffer, with pointer tracking, flow control and a level interrupt.
module cpu2core_ring_writer
  import cpu2core_ring_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snk_valid,
  input  logic [DATA_W-1:0] snk_data,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  ring_state_t     state;
  logic [ADDR_W:0] acc_ptr;
  logic [ADDR_W:0] cmt_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] level;
  logic [ADDR_W:0] threshold;
  logic            enable;
  logic            irq_en;
  logic            full;
  logic            accept;

  // Flow control uses the accepted pointer so the in-flight write is already counted.
  assign level     = acc_ptr - rd_ptr;
  assign full      = (level == DEPTH);
  assign snk_ready = (state == ST_RUN) && enable && !full;
  assign accept    = snk_valid && snk_ready;

  cpu2core_ring_csr #(.ADDR_W(ADDR_W)) u_csr (
    .clk           (clk),
    .reset         (reset),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .cmt_ptr       (cmt_ptr),
    .level         (level),
    .state         (state),
    .full_hit_set  (snk_valid && full),
    .enable        (enable),
    .irq_en        (irq_en),
    .threshold     (threshold),
    .rd_ptr        (rd_ptr)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_DISABLED;
      acc_ptr        <= '0;
      cmt_ptr        <= '0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= 4'h0;
      mem_writedata  <= '0;
      irq            <= 1'b0;
    end else begin
      mem_write      <= accept;
      mem_chipselect <= accept;
      mem_byteenable <= accept ? 4'hF : 4'h0;
      if (accept) begin
        mem_address   <= acc_ptr[ADDR_W-1:0];
        mem_writedata <= snk_data;
        acc_ptr       <= acc_ptr + 1'b1;
      end
      // The consumer-visible pointer advances only once the word has reached memory.
      if (mem_write) cmt_ptr <= cmt_ptr + 1'b1;
      irq <= irq_en && (level >= threshold);

      unique case (state)
        ST_DISABLED: if (enable)     state <= ST_RUN;
        ST_RUN:      if (!enable)    state <= ST_DRAIN;
        ST_DRAIN:    if (!mem_write) state <= ST_DISABLED;
        default:                     state <= ST_DISABLED;
      endcase
    end
  end

endmodule
